// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
package riscv_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 8;
  localparam int unsigned INSTR_W        = 32;
  // Queue entries carry a full-width pc so one struct serves every ADDR_W up to 32.
  localparam int unsigned PC_W           = 32;
  localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0013;

  typedef enum logic [0:0] {
    StFetch,
    StHalt
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory, decode handshake and redirect signals of the fetch unit.
interface fetch_unit_if
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) ();

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halted;

  // Fetch unit side.
  modport master (
    output imem_addr,
    input  imem_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_pc,
    output halted
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_addr,
    output imem_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_pc,
    input  halted
  );

endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetched instructions with synchronous flush.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            push_i,
  input  fetch_entry_t    push_data_i,
  input  logic            pop_i,
  output fetch_entry_t    head_o,
  output logic [CntW-1:0] count_o
);

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next-state: flush wins over push/pop; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_q] = push_data_i;
        wr_d        = wr_q + PtrW'(1);
      end
      if (pop_i) begin
        rd_d = rd_q + PtrW'(1);
      end
      cnt_d = cnt_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  // State register; storage is cleared on reset so the head reads as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC, 1-cycle synchronous imem, decoupling queue, redirect.
// Optional feature macro: FETCH_HALT_STOP_EN (an all-zero response word stops fetching).
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RESET_PC = 0
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [CntW-1:0]   count;
  logic [CntW:0]     occ;
  logic              pop, push, issue, halt_hit;
  fetch_entry_t      push_data, head;
  logic              unused_head_pc;

`ifdef FETCH_HALT_STOP_EN
  assign halt_hit   = inflight_q & (bus.imem_data == '0);
  assign bus.halted = (state_q == StHalt);
`else
  assign halt_hit   = 1'b0;
  assign bus.halted = 1'b0;
`endif

  assign pop = bus.out_valid & bus.out_ready;

  // Queue control: redirect discards the response; occupancy counts the slot an in-flight
  // response will need so a full queue never loses a word.
  always_comb begin
    push_data       = '0;
    push_data.instr = bus.imem_data;
    push_data.pc    = PC_W'(inflight_pc_q);
    push            = inflight_q & ~bus.redirect_valid & ~halt_hit;
    occ             = {1'b0, count} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
    issue           = (state_q == StFetch) & (occ < (CntW + 1)'(DEPTH))
                      & ~bus.redirect_valid & ~halt_hit;
  end

  // Next-state for PC, in-flight tracking and the FETCH/HALT FSM.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (issue) begin
      pc_d          = pc_q + ADDR_W'(4);
      inflight_pc_d = pc_q;
    end
    if (bus.redirect_valid) begin
      pc_d    = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      state_d = StFetch;
    end else if (halt_hit) begin
      state_d = StHalt;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StFetch;
      pc_q          <= ADDR_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (bus.redirect_valid),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc[ADDR_W-1:0];
  assign unused_head_pc = ^head.pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, meaning byte-address width of the instruction memory port and of every PC field.
REQ-002 Parameter DEPTH, default 2, meaning entries in the internal instruction queue (power of two, >=2).
REQ-003 Parameter RESET_PC, default 0, meaning word-aligned PC loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 imem_addr  output  ADDR_W  byte address driven to instruction memory; equals current PC.
REQ-007 imem_data  input  32  instruction word for the address presented in the previous cycle (1-cycle synchronous read).
REQ-008 out_valid  output  1  head-of-queue instruction available to decode.
REQ-009 out_ready  input  1  decode accepts the head entry this cycle.
REQ-010 out_instr  output  32  head instruction word.
REQ-011 out_pc  output  ADDR_W  byte address of out_instr.
REQ-012 redirect_valid  input  1  branch/jump redirect request.
REQ-013 redirect_pc  input  ADDR_W  redirect target; bits [1:0] forced to 0.
REQ-014 halted  output  1  fetch stopped (see Configuration).

Function
REQ-015 FSM states: FETCH, HALT; reset enters FETCH.
REQ-016 Issue condition: state==FETCH and (count + inflight - pop) < DEPTH, where pop = out_valid & out_ready.
REQ-017 On issue: pc <= pc + 4 modulo 2^ADDR_W (0xFC wraps to 0x00 at ADDR_W=8); inflight <= 1; inflight_pc <= pc.
REQ-018 Cycle after an issue: {imem_data, inflight_pc} pushed into queue tail at that edge unless discarded.
REQ-019 out_valid = (count != 0); out_instr/out_pc reflect head combinationally from queue storage.
REQ-020 Handshake: entry removed only on out_valid & out_ready; head stable while out_valid & !out_ready.
REQ-021 Simultaneous push and pop: count unchanged; pop on empty queue impossible.
REQ-022 Full queue: no issue; held instruction never overwritten or dropped.
REQ-023 Redirect has priority over push, pop and issue in the same cycle: queue cleared, in-flight response discarded, pc <= redirect_pc, state <= FETCH.
REQ-024 Redirect latency: out_valid low cycle after redirect; target instruction valid at out no earlier than 2 cycles after redirect edge.
REQ-025 Startup latency: RESET_PC issued first cycle rst_n high; out_valid asserted 2 cycles later.

Reset
REQ-026 While rst_n low at a clock edge: pc=RESET_PC, count=0, inflight=0, queue pointers 0, out_instr=0, out_pc=0, out_valid=0, halted=0, state=FETCH.
REQ-027 Reset mid-operation discards in-flight response and all queued entries; no stale entry emerges after release.

Configuration
REQ-028 Macro FETCH_HALT_STOP_EN: when defined, a response word 32'h00000000 is not pushed; state -> HALT, no further issues, halted=1, queued entries still drain; redirect exits HALT.
REQ-029 Without FETCH_HALT_STOP_EN: no HALT state, halted tied 0, all-zero words delivered as ordinary instructions.

Structure
REQ-030 Shared package riscv_pkg holds ADDR_W default, INSTR_W=32, NOP constant 32'h00000013, fetch_state_t enum, fetch_entry_t struct {instr, pc}.
REQ-031 Queue implemented as sub-module fetch_queue (DEPTH-entry FIFO with synchronous flush, push, pop, count).

Verification
REQ-032 Reset release, IMEM[0]=32'h00600113, IMEM[4]=32'h00f00193, out_ready=1 -> out_instr 00600113/pc 00 then 00f00193/pc 04 on consecutive cycles, first valid 2 cycles after release.
REQ-033 out_ready=0 for 10 cycles -> queue fills to DEPTH, issues stop, imem_addr frozen, head stays 00600113; ready=1 -> in-order delivery, no loss.
REQ-034 Redirect to 0x20 while queue full and response in flight -> out_valid low next cycle, next delivered pc 0x20, no 0x08/0x0C entries appear.
REQ-035 RESET_PC=0xF8 -> delivered pcs F8, FC, 00, 04.
REQ-036 FETCH_HALT_STOP_EN defined, IMEM[8]=0 -> pcs 00, 04 delivered, halted=1, no issues; redirect to 0x00 -> halted=0, pc 00 redelivered.
REQ-037 rst_n low for one cycle mid-stream with queue full -> out_valid=0 next cycle, restart at RESET_PC.
